// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster-order grayscale frame.
// Two shift-register line buffers feed the right-hand column of a register window.
//
// state  | meaning
// IDLE   | waiting for start_i, pixel strobes ignored
// ACTIVE | accepting pixels; last_q marks the final pixel already taken
// DONE   | single-cycle frame_done_o pulse, then back to IDLE
module sobel_window_gen #(
  parameter int PX_BITS    = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 start_i,
  input  logic                 px_rdy_i,
  input  logic [PX_BITS-1:0]   in_px_i,
  output logic [9*PX_BITS-1:0] win_o,
  output logic                 win_rdy_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               last_q;
  logic               accept;
  logic               at_last_col;
  logic               at_last_row;

  logic [PX_BITS-1:0] lb1 [IMG_WIDTH];
  logic [PX_BITS-1:0] lb2 [IMG_WIDTH];
  logic [PX_BITS-1:0] win [9];

  // start_i always wins over a coincident pixel strobe
  assign accept      = (state == ACTIVE) && px_rdy_i && !start_i && !last_q;
  assign at_last_col = (col == CW'(IMG_WIDTH - 1));
  assign at_last_row = (row == RW'(IMG_HEIGHT - 1));

  assign busy_o       = (state == ACTIVE);
  assign frame_done_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      last_q    <= 1'b0;
      win_rdy_o <= 1'b0;
    end else begin
      win_rdy_o <= accept && (row >= RW'(2)) && (col >= CW'(2));
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= ACTIVE;
            col    <= '0;
            row    <= '0;
            last_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (start_i) begin
            col    <= '0;
            row    <= '0;
            last_q <= 1'b0;
          end else if (last_q) begin
            state <= DONE;
          end else if (accept) begin
            if (at_last_col) begin
              col <= '0;
              if (at_last_row) last_q <= 1'b1;
              else             row    <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          last_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The tail of each buffer is the pixel one (lb1) or two (lb2) lines above
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[0] <= in_px_i;
      lb2[0] <= lb1[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1[i] <= lb1[i-1];
        lb2[i] <= lb2[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb2[IMG_WIDTH-1];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[IMG_WIDTH-1];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_px_i;
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_pack
    assign win_o[g*PX_BITS +: PX_BITS] = win[g];
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen: vector table, directed frames and
// randomized frames compared against a frame-image reference model.
module tb_sobel_window_gen;
  localparam int W = 16;
  localparam int H = 16;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        start_i;
  logic        px_rdy_i;
  logic [7:0]  in_px_i;
  logic [71:0] win_o;
  logic        win_rdy_o;
  logic        busy_o;
  logic        frame_done_o;

  always #5 clk_i = ~clk_i;

  sobel_window_gen #(.PX_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i), .px_rdy_i(px_rdy_i),
    .in_px_i(in_px_i), .win_o(win_o), .win_rdy_o(win_rdy_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 taking pixels, 2 frame complete awaiting done, 3 done pulse
  int          mode = 0;
  int          mr = 0, mc = 0;
  int          img [H][W];
  logic        exp_rdy = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_win_chk = 1'b0;
  logic [71:0] exp_win = '0;
  int          win_cnt = 0;
  logic        seen_first = 1'b0;
  logic [71:0] first_win = '0, last_win = '0;

  typedef struct {
    logic       rst, st, pr;
    logic [7:0] px;
    logic       busy, rdy, done;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst, input logic st, input logic pr, input logic [7:0] px);
    nreset_i = ~rst; start_i = st; px_rdy_i = pr; in_px_i = px;
    exp_rdy = 1'b0; exp_win_chk = 1'b0;
    if (rst) begin
      mode = 0; exp_win = '0; exp_win_chk = 1'b1;
    end else begin
      case (mode)
        0: if (st) begin mode = 1; mr = 0; mc = 0; end
        1: begin
          if (st) begin
            mr = 0; mc = 0;
          end else if (pr) begin
            img[mr][mc] = int'(px);
            if (mr >= 2 && mc >= 2) begin
              exp_rdy = 1'b1; exp_win_chk = 1'b1;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  exp_win[(i*3+j)*8 +: 8] = 8'(img[mr-2+i][mc-2+j]);
            end
            if (mr == H-1 && mc == W-1) mode = 2;
            else if (mc == W-1) begin mc = 0; mr++; end
            else mc++;
          end
        end
        2: if (st) begin mode = 1; mr = 0; mc = 0; end else mode = 3;
        default: mode = 0;
      endcase
    end
    exp_busy = (mode == 1 || mode == 2);
    exp_done = (mode == 3);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
    chk("win_rdy", 72'(win_rdy_o), 72'(exp_rdy));
    chk("busy", 72'(busy_o), 72'(exp_busy));
    chk("frame_done", 72'(frame_done_o), 72'(exp_done));
    if (exp_win_chk) chk("win", win_o, exp_win);
    if (win_rdy_o) begin
      win_cnt++;
      if (!seen_first) begin first_win = win_o; seen_first = 1'b1; end
      last_win = win_o;
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic pr, input logic [7:0] px);
    apply(rst, st, pr, px);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'(($urandom)));
  endtask

  task automatic clear_stats();
    win_cnt = 0; seen_first = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] v, input int gapmax);
    cyc(1'b0, 1'b0, 1'b1, v);
    repeat ($urandom_range(gapmax, 0)) cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic full_frame(input int gapmax, input bit rand_vals);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(rand_vals ? 8'($urandom) : 8'(r*16 + c), gapmax);
  endtask

  task automatic ramp_part(input int npx);
    for (int k = 0; k < npx; k++) send_px(8'(k), 0);
  endtask

  task automatic check_ramp_frame(input string tag);
    chk({tag, "_count"}, 72'(win_cnt), 72'(196));
    chk({tag, "_first"}, first_win, pack9(0, 1, 2, 16, 17, 18, 32, 33, 34));
    chk({tag, "_last"}, last_win, pack9(221, 222, 223, 237, 238, 239, 253, 254, 255));
  endtask

  initial begin
    nreset_i = 1'b0; start_i = 1'b0; px_rdy_i = 1'b0; in_px_i = '0;

    // reset, idle strobes ignored, start, one pixel, start+pixel collision
    tbl[0] = '{rst:1, st:0, pr:0, px:8'd0, busy:0, rdy:0, done:0};
    tbl[1] = '{rst:0, st:0, pr:1, px:8'd5, busy:0, rdy:0, done:0};
    tbl[2] = '{rst:0, st:0, pr:1, px:8'd7, busy:0, rdy:0, done:0};
    tbl[3] = '{rst:0, st:1, pr:0, px:8'd0, busy:1, rdy:0, done:0};
    tbl[4] = '{rst:0, st:0, pr:1, px:8'd0, busy:1, rdy:0, done:0};
    tbl[5] = '{rst:0, st:1, pr:1, px:8'd9, busy:1, rdy:0, done:0};
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].pr, tbl[i].px);
      chk("tbl_busy", 72'(busy_o), 72'(tbl[i].busy));
      chk("tbl_rdy", 72'(win_rdy_o), 72'(tbl[i].rdy));
      chk("tbl_done", 72'(frame_done_o), 72'(tbl[i].done));
    end

    // back-to-back ramp frame following the collision above
    clear_stats();
    full_frame(0, 1'b0);
    idle(3);
    check_ramp_frame("b2b");
    chk("b2b_idle_busy", 72'(busy_o), 72'(0));

    // ramp frame with random gaps
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    clear_stats();
    full_frame(5, 1'b0);
    idle(3);
    check_ramp_frame("gaps");

    // reset one cycle after pixel (5,7), then a clean frame
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    ramp_part(5*16 + 8);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    clear_stats();
    idle(6);
    chk("rst_abort_windows", 72'(win_cnt), 72'(0));
    chk("rst_abort_busy", 72'(busy_o), 72'(0));
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    clear_stats();
    full_frame(0, 1'b0);
    idle(3);
    check_ramp_frame("after_rst");

    // start_i coincident with pixel (4,4)
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    ramp_part(4*16 + 4);
    clear_stats();
    cyc(1'b0, 1'b1, 1'b1, 8'd68);
    full_frame(0, 1'b0);
    idle(3);
    check_ramp_frame("restart");

    // randomized pixel values and gaps, model-checked window by window
    for (int f = 0; f < 2; f++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'd0);
      clear_stats();
      full_frame(3, 1'b1);
      idle(3);
      chk("rand_count", 72'(win_cnt), 72'(196));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
